// File: rtl/dow_pkg.sv
// Shared types, limits and calendar helpers for the day-of-week arbiter.
package dow_pkg;

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    localparam logic [2:0] SUN = 3'd0;
    localparam logic [2:0] MON = 3'd1;
    localparam logic [2:0] TUE = 3'd2;
    localparam logic [2:0] WED = 3'd3;
    localparam logic [2:0] THU = 3'd4;
    localparam logic [2:0] FRI = 3'd5;
    localparam logic [2:0] SAT = 3'd6;

    localparam logic [11:0] YEAR_MIN = 12'd1700;
    localparam logic [11:0] YEAR_MAX = 12'd2399;

    function automatic logic is_leap(input logic [11:0] year);
        return (((year % 12'd4) == 12'd0) && ((year % 12'd100) != 12'd0))
            || ((year % 12'd400) == 12'd0);
    endfunction

    // Returns 0 for an out-of-range month so any date compares as too large.
    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        case (month)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: return 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    return 5'd30;
            4'd2:                                       return leap ? 5'd29 : 5'd28;
            default:                                    return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/date_converter.sv
// Combinational Gregorian weekday (0=Sunday) for years 1700..2399 via
// century/month key codes; result is meaningless for invalid dates.
module date_converter
    import dow_pkg::*;
(
    input  logic [4:0]  i_date,
    input  logic [3:0]  i_month,
    input  logic [11:0] i_year,
    output logic [2:0]  o_day
);

    logic [5:0] w_century;
    logic [6:0] w_yy;
    logic [2:0] w_mcode;
    logic [2:0] w_ccode;
    logic       w_jf_corr;
    logic [7:0] w_sum;

    always_comb begin
        w_century = 6'(i_year / 12'd100);
        w_yy      = 7'(i_year % 12'd100);
        w_jf_corr = is_leap(i_year) && ((i_month == 4'd1) || (i_month == 4'd2));

        case (i_month)
            4'd1, 4'd10: w_mcode = 3'd0;
            4'd2, 4'd3, 4'd11: w_mcode = 3'd3;
            4'd4, 4'd7:  w_mcode = 3'd6;
            4'd5:        w_mcode = 3'd1;
            4'd6:        w_mcode = 3'd4;
            4'd8:        w_mcode = 3'd2;
            4'd9, 4'd12: w_mcode = 3'd5;
            default:     w_mcode = 3'd0;
        endcase

        case (w_century[1:0])
            2'd0:    w_ccode = 3'd6;
            2'd1:    w_ccode = 3'd4;
            2'd2:    w_ccode = 3'd2;
            default: w_ccode = 3'd0;
        endcase

        // Max sum 99+24+6+6+31 = 166, so 8 bits never wraps before the mod.
        w_sum = {1'b0, w_yy} + {3'b0, w_yy[6:2]} + {5'b0, w_mcode}
              + {5'b0, w_ccode} + {3'b0, i_date} - {7'b0, w_jf_corr};
        o_day = 3'(w_sum % 8'd7);
    end

endmodule

// File: rtl/dow_arbiter.sv
// Round-robin front end sharing one date_converter among N_REQ requesters,
// with date validation and a valid/ready tagged response.
module dow_arbiter
    import dow_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [5*N_REQ-1:0]   req_date,
    input  logic [4*N_REQ-1:0]   req_month,
    input  logic [12*N_REQ-1:0]  req_year,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2:0]           rsp_day,
    output logic                 rsp_err
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_gid;
    logic [ID_W-1:0]     w_gid;
    logic                w_found;
    logic [2*N_REQ-1:0]  w_dbl;
    logic [N_REQ-1:0]    w_rot;
    logic [4:0]          r_date;
    logic [3:0]          r_month;
    logic [11:0]         r_year;
    logic [2:0]          w_conv_day;
    logic                w_leap;
    logic [4:0]          w_dim;
    logic                w_err;
    logic [ID_W-1:0]     r_rsp_id;
    logic [2:0]          r_rsp_day;
    logic                r_rsp_err;

    // Rotate so rr_ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        w_dbl   = {req_valid, req_valid} >> r_rr_ptr;
        w_rot   = w_dbl[N_REQ-1:0];
        w_found = 1'b0;
        w_gid   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_gid   = ID_W'((i + r_rr_ptr) % unsigned'(N_REQ));
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if ((r_state == IDLE) && w_found) begin
            req_ready[w_gid] = 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next_state = CALC;
            CALC:    w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_leap = is_leap(r_year);
        w_dim  = days_in_month(r_month, w_leap);
        w_err  = (r_year < YEAR_MIN) || (r_year > YEAR_MAX)
              || (r_month == 4'd0) || (r_month > 4'd12)
              || (r_date == 5'd0) || (r_date > w_dim);
    end

    date_converter u_conv (
        .i_date  (r_date),
        .i_month (r_month),
        .i_year  (r_year),
        .o_day   (w_conv_day)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_gid     <= '0;
            r_date    <= '0;
            r_month   <= '0;
            r_year    <= '0;
            r_rsp_id  <= '0;
            r_rsp_day <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gid   <= w_gid;
                        r_date  <= req_date[5*w_gid +: 5];
                        r_month <= req_month[4*w_gid +: 4];
                        r_year  <= req_year[12*w_gid +: 12];
                    end
                end
                CALC: begin
                    r_rsp_id  <= r_gid;
                    r_rsp_err <= w_err;
                    r_rsp_day <= w_err ? SUN : w_conv_day;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rr_ptr <= ID_W'((r_gid + 1) % unsigned'(N_REQ));
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_day   = r_rsp_day;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dow_arbiter.sv
// Scoreboard bench for dow_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on each accepted response.
module tb_dow_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [5*N-1:0]  req_date;
    logic [4*N-1:0]  req_month;
    logic [12*N-1:0] req_year;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [2:0]      rsp_day;
    logic            rsp_err;

    dow_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_date  (req_date),
        .req_month (req_month),
        .req_year  (req_year),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_day   (rsp_day),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int day;
        int err;
    } exp_t;

    typedef struct {
        int d;
        int m;
        int y;
        int day;
        int err;
    } vec_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rsp_id", int'(rsp_id), e.id);
                chk("rsp_day", int'(rsp_day), e.day);
                chk("rsp_err", int'(rsp_err), e.err);
            end
        end
    end

    task automatic set_req(input int idx, input int d, input int m, input int y);
        req_date[5*idx +: 5]   = 5'(d);
        req_month[4*idx +: 4]  = 4'(m);
        req_year[12*idx +: 12] = 12'(y);
    endtask

    // Raise one request, wait for its grant, record the expectation, withdraw.
    task automatic issue(input int idx, input int d, input int m, input int y,
                         input int eday, input int eerr);
        int t;
        @(posedge clk); #1;
        set_req(idx, d, m, y);
        req_valid[idx] = 1'b1;
        t = 0;
        @(negedge clk);
        while (req_ready[idx] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("grant", int'(req_ready), 1 << idx);
        q.push_back('{id: idx, day: eday, err: eerr});
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    vec_t vecs[12] = '{
        '{29,  2, 2000, 2, 0},
        '{29,  2, 1900, 0, 1},
        '{ 1,  1, 2000, 6, 0},
        '{10, 13, 2024, 0, 1},
        '{ 0,  5, 2024, 0, 1},
        '{31,  4, 2024, 0, 1},
        '{ 1,  1, 1699, 0, 1},
        '{ 1,  1, 2400, 0, 1},
        '{ 4,  7, 1776, 4, 0},
        '{31, 12, 2399, 5, 0},
        '{ 1,  1, 1700, 5, 0},
        '{29,  2, 2024, 4, 0}
    };

    exp_t rr_exp[4] = '{
        '{id: 0, day: 5, err: 0},
        '{id: 1, day: 6, err: 0},
        '{id: 2, day: 4, err: 0},
        '{id: 3, day: 0, err: 1}
    };

    initial begin
        int t;
        int saw;
        rst_n     = 1'b0;
        req_valid = '0;
        req_date  = '0;
        req_month = '0;
        req_year  = '0;
        rsp_ready = 1'b1;

        #12;
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_day", int'(rsp_day), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single request: same-cycle grant, response two cycles later.
        @(posedge clk); #1;
        set_req(0, 15, 3, 2024);
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("t1_grant", int'(req_ready), 1);
        q.push_back('{id: 0, day: 5, err: 0});
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("t1_calc_no_valid", int'(rsp_valid), 0);
        chk("t1_calc_no_ready", int'(req_ready), 0);
        @(negedge clk);
        chk("t1_resp_valid", int'(rsp_valid), 1);
        wait_drain();

        foreach (vecs[k]) begin
            issue(k % N, vecs[k].d, vecs[k].m, vecs[k].y, vecs[k].day, vecs[k].err);
            wait_drain();
        end

        // Backpressure with req1 queued behind an in-flight req0.
        rsp_ready = 1'b0;
        issue(0, 1, 1, 2000, 6, 0);
        set_req(1, 31, 12, 2399);
        req_valid[1] = 1'b1;
        t = 0;
        @(negedge clk);
        while (rsp_valid !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("bp_rsp_seen", int'(rsp_valid), 1);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold", int'({rsp_valid, rsp_id, rsp_day, rsp_err, req_ready}),
                int'({1'b1, 2'd0, 3'd6, 1'b0, 4'b0000}));
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_next_grant", int'(req_ready), 2);
        q.push_back('{id: 1, day: 5, err: 0});
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_drain();

        // Reset while in CALC drops the transaction.
        @(posedge clk); #1;
        set_req(2, 4, 7, 1776);
        req_valid[2] = 1'b1;
        @(negedge clk);
        chk("rc_grant", int'(req_ready), 4);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rc_rsp_valid", int'(rsp_valid), 0);
        chk("rc_rsp_id", int'(rsp_id), 0);
        chk("rc_rsp_day", int'(rsp_day), 0);
        chk("rc_rsp_err", int'(rsp_err), 0);
        chk("rc_req_ready", int'(req_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) saw = 1;
        end
        chk("rc_no_rsp", saw, 0);

        // Fairness with all requesters held valid; first grant after reset is 0.
        @(posedge clk); #1;
        set_req(0, 15, 3, 2024);
        set_req(1, 1, 1, 2000);
        set_req(2, 4, 7, 1776);
        set_req(3, 29, 2, 1900);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            t = 0;
            @(negedge clk);
            while (req_ready === '0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("rr_grant", int'(req_ready), 1 << (k % N));
            q.push_back(rr_exp[k % N]);
            @(posedge clk); #1;
        end
        req_valid = '0;
        wait_drain();

        repeat (3) @(negedge clk);
        chk("final_queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
